// File: rtl/mdu_alu_ctrl.sv
// Execute-stage control: single-cycle ALU op decode plus an iterative
// multiply/divide unit that owns the HI/LO registers and stalls the pipe while busy.
module mdu_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_in,
  input  logic [1:0]       i_aluop,
  input  logic [5:0]       i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [2:0]       o_alu_ctl,
  output logic [WIDTH-1:0] o_mdu_result,
  output logic             o_is_mf,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_lq;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_rtype;
  logic               w_muldiv;
  logic               w_mfhi;
  logic               w_mflo;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_mdu_op;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_rtype  = i_valid_in && (i_aluop == 2'b10);
  assign w_muldiv = w_rtype && (i_func[5:2] == 4'b0110);
  assign w_mfhi   = w_rtype && (i_func == 6'b010000);
  assign w_mflo   = w_rtype && (i_func == 6'b010010);
  assign w_mthi   = w_rtype && (i_func == 6'b010001);
  assign w_mtlo   = w_rtype && (i_func == 6'b010011);
  assign w_mdu_op = w_muldiv || w_mfhi || w_mflo || w_mthi || w_mtlo;

  assign o_stall = w_mdu_op && (r_state != IDLE);
  assign o_busy  = (r_state != IDLE);
  assign o_is_mf = w_mfhi || w_mflo;
  assign o_done  = r_done;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

  // Signed ops (even func codes) work on magnitudes; signs are fixed up in FIX.
  assign w_signed = ~i_func[0];
  assign w_sa     = w_signed & i_a[WIDTH-1];
  assign w_sb     = w_signed & i_b[WIDTH-1];
  assign w_mag_a  = w_sa ? (~i_a + {{(WIDTH-1){1'b0}}, 1'b1}) : i_a;
  assign w_mag_b  = w_sb ? (~i_b + {{(WIDTH-1){1'b0}}, 1'b1}) : i_b;

  assign w_addend = r_lq[0] ? r_opb : {WIDTH{1'b0}};
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_shift  = {r_acc, r_lq[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_opb});
  assign w_sub    = w_shift[WIDTH-1:0] - r_opb;

  // A zero divisor leaves the dividend in the remainder, so only the quotient needs forcing.
  assign w_prod     = {r_acc, r_lq};
  assign w_prod_fix = r_neg_q ? (~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_prod;
  assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} :
                      (r_neg_q ? (~r_lq + {{(WIDTH-1){1'b0}}, 1'b1}) : r_lq);
  assign w_rem_fix  = r_neg_r ? (~r_acc + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc;

  always_comb begin
    o_alu_ctl = 3'b010;
    case (i_aluop)
      2'b00: o_alu_ctl = 3'b010;
      2'b01: o_alu_ctl = 3'b110;
      2'b11: o_alu_ctl = 3'b011;
      2'b10: begin
        case (i_func[3:0])
          4'b0000: o_alu_ctl = 3'b010;
          4'b0010: o_alu_ctl = 3'b110;
          4'b0100: o_alu_ctl = 3'b000;
          4'b0101: o_alu_ctl = 3'b001;
          4'b1010: o_alu_ctl = 3'b111;
          default: o_alu_ctl = 3'b010;
        endcase
      end
      default: o_alu_ctl = 3'b010;
    endcase
  end

  always_comb begin
    o_mdu_result = {WIDTH{1'b0}};
    if (w_mfhi) begin
      o_mdu_result = r_hi;
    end else if (w_mflo) begin
      o_mdu_result = r_lo;
    end else begin
      o_mdu_result = {WIDTH{1'b0}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_lq     <= {WIDTH{1'b0}};
      r_opb    <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_muldiv) begin
            r_state  <= RUN;
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_lq     <= w_mag_a;
            r_opb    <= w_mag_b;
            r_is_div <= i_func[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dz     <= (i_b == {WIDTH{1'b0}});
          end else if (w_mthi) begin
            r_hi <= i_a;
          end else if (w_mtlo) begin
            r_lo <= i_a;
          end
        end
        // Multiply: shift-add into {acc,lq}. Divide: restoring step, lq holds quotient.
        RUN: begin
          if (r_is_div) begin
            r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_lq  <= {r_lq[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_lq  <= {w_sum[0], r_lq[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == LAST_CNT) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_alu_ctrl.sv
// Scoreboard bench for mdu_alu_ctrl: stimulus pushes expected HI/LO pairs,
// a monitor pops and compares them on every done pulse.
module tb_mdu_alu_ctrl;

  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [1:0]   aluop;
  logic [5:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_ctl;
  logic [W-1:0] mdu_result;
  logic         is_mf;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q_hi[$];
  logic [W-1:0] q_lo[$];

  always #5 clk = ~clk;

  mdu_alu_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_in(valid_in), .i_aluop(aluop),
    .i_func(func), .i_a(a), .i_b(b), .o_alu_ctl(alu_ctl),
    .o_mdu_result(mdu_result), .o_is_mf(is_mf), .o_stall(stall),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q_hi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        chk("done_hi", hi, q_hi.pop_front());
        chk("done_lo", lo, q_lo.pop_front());
      end
    end
  end

  task automatic issue_muldiv(input logic [5:0] f, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                              input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit push);
    @(posedge clk); #1;
    valid_in = 1'b1; aluop = 2'b10; func = f; a = ta; b = tb_v;
    #1;
    chk("accept_stall", {31'd0, stall}, 32'd0);
    if (push) begin
      q_hi.push_back(ehi);
      q_lo.push_back(elo);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; func = 6'd0; aluop = 2'b00;
  endtask

  task automatic wait_done(output int nbusy);
    bit seen;
    seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    chk("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] dec_op [9];
    logic [5:0] dec_fn [9];
    logic [2:0] dec_ex [9];
    int nb;
    int stall_bad;
    bit seen;

    dec_op = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    dec_fn = '{F_MULT, F_MULT, F_MULT, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101111};
    dec_ex = '{3'b010, 3'b110, 3'b011, 3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    rst = 1'b1; valid_in = 1'b0; aluop = 2'b00; func = 6'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; aluop = dec_op[i]; func = dec_fn[i]; a = 32'd5; b = 32'd9;
      #1;
      chk("decode_alu_ctl", {29'd0, alu_ctl}, {29'd0, dec_ex[i]});
      chk("decode_stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("decode_no_busy", {31'd0, busy}, 32'd0);

    issue_muldiv(F_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    wait_done(nb);
    chk("multu_busy_cycles", nb, 32'd33);
    issue_muldiv(F_MULT, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
    wait_done(nb);
    issue_muldiv(F_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    wait_done(nb);
    issue_muldiv(F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    wait_done(nb);
    issue_muldiv(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b1);
    wait_done(nb);
    issue_muldiv(F_DIV, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD, 1'b1);
    wait_done(nb);
    issue_muldiv(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(nb);
    issue_muldiv(F_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    wait_done(nb);

    // ADD flows during busy; MULT result checked by the monitor.
    issue_muldiv(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1);
    valid_in = 1'b1; aluop = 2'b10; func = F_ADD;
    #1;
    chk("add_busy", {31'd0, busy}, 32'd1);
    chk("add_stall", {31'd0, stall}, 32'd0);
    chk("add_alu_ctl", {29'd0, alu_ctl}, 32'd2);
    valid_in = 1'b0;
    wait_done(nb);

    // Dependent MFLO right after accept: stalled until busy falls, then reads new LO.
    issue_muldiv(F_MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b1);
    valid_in = 1'b1; aluop = 2'b10; func = F_MFLO;
    nb = 0; stall_bad = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (!stall) stall_bad++;
      end else begin
        seen = 1'b1;
        chk("mflo_release_stall", {31'd0, stall}, 32'd0);
        chk("mflo_result", mdu_result, 32'h23456780);
        chk("mflo_is_mf", {31'd0, is_mf}, 32'd1);
      end
    end
    chk("mflo_seen", {31'd0, seen}, 32'd1);
    chk("mflo_stall_held", stall_bad, 32'd0);
    chk("mflo_busy_cycles", nb, 32'd33);
    @(posedge clk); #1 valid_in = 1'b0;

    // Reset at cnt==10 discards the DIV; no expectation is pushed.
    issue_muldiv(F_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    repeat (40) @(posedge clk);
    issue_muldiv(F_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    wait_done(nb);

    @(posedge clk); #1;
    valid_in = 1'b1; aluop = 2'b10; func = F_MTHI; a = 32'h1234;
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("mthi_idle", hi, 32'h1234);

    // MTLO during busy waits for done, then overwrites the FIX value.
    issue_muldiv(F_MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 1'b1);
    valid_in = 1'b1; aluop = 2'b10; func = F_MTLO; a = 32'hABCD;
    stall_bad = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (busy) begin
        if (!stall) stall_bad++;
      end else begin
        seen = 1'b1;
        chk("mtlo_release_stall", {31'd0, stall}, 32'd0);
      end
    end
    chk("mtlo_stall_held", stall_bad, 32'd0);
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("mtlo_applied", lo, 32'hABCD);
    chk("mtlo_hi_kept", hi, 32'd0);

    repeat (5) @(posedge clk);
    chk("queue_drained", q_hi.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
